// File: rtl/lc4_regfile_mp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lc4_regfile_mp_pkg
// Purpose  : Shared definitions for the multi-pipe LC4 register file:
//            default LC4 widths, selector-width derivation and helpers that
//            locate a pipe's slice inside a packed multi-pipe bus.
// Revision : 1.0  initial release
// ============================================================================
package lc4_regfile_mp_pkg;

    // LC4 defaults: 16-bit datapath, 8 architectural registers, 2 pipes.
    localparam int LC4_N     = 16;
    localparam int LC4_NREGS = 8;
    localparam int LC4_PIPES = 2;

    // Selector width needed to address nregs registers. Guarded so that a
    // degenerate single-register file still gets a 1-bit selector.
    function automatic int lc4_aw(input int nregs);
        return (nregs < 2) ? 1 : $clog2(nregs);
    endfunction

    // LSB of pipe p's field in a bus packed as {pipe[P-1], ..., pipe[0]}.
    function automatic int slice_lsb(input int p, input int width);
        return p * width;
    endfunction

    // MSB of pipe p's field in the same packing.
    function automatic int slice_msb(input int p, input int width);
        return (p * width) + width - 1;
    endfunction

endpackage : lc4_regfile_mp_pkg
`default_nettype wire

// File: rtl/lc4_regfile_mp_wsel.sv
`default_nettype none
// ============================================================================
// Module   : lc4_rf_wsel
// Purpose  : Winning-write selector. For one register index, scans every
//            pipe's write port and reports whether any pipe writes that
//            register this cycle and, if so, the data of the highest-index
//            writer (younger pipe wins a same-cycle conflict).
// Ports    : i_sel    - register index being resolved
//            i_rd     - per-pipe write destinations, pipe p at [p*AW +: AW]
//            i_rd_we  - per-pipe write enables
//            i_wdata  - per-pipe write data, pipe p at [p*n +: n]
//            o_we     - some pipe writes i_sel this cycle
//            o_data   - winning data (zero when o_we is low)
// Revision : 1.0  initial release
// ============================================================================
module lc4_rf_wsel
    import lc4_regfile_mp_pkg::*;
#(
    parameter int n     = LC4_N,
    parameter int PIPES = LC4_PIPES,
    parameter int AW    = lc4_aw(LC4_NREGS)
) (
    input  logic [AW-1:0]       i_sel,
    input  logic [PIPES*AW-1:0] i_rd,
    input  logic [PIPES-1:0]    i_rd_we,
    input  logic [PIPES*n-1:0]  i_wdata,
    output logic                o_we,
    output logic [n-1:0]        o_data
);

    // Ascending scan: a later (higher-index) match overwrites an earlier
    // one, which realises highest-index-wins priority.
    always_comb begin
        o_we   = 1'b0;
        o_data = '0;
        for (int p = 0; p < PIPES; p++) begin
            if (i_rd_we[p] && (i_rd[p*AW +: AW] == i_sel)) begin
                o_we   = 1'b1;
                o_data = i_wdata[p*n +: n];
            end
        end
    end

endmodule : lc4_rf_wsel
`default_nettype wire

// File: rtl/lc4_regfile_mp.sv
`default_nettype none
// ============================================================================
// Module   : lc4_regfile_mp
// Purpose  : Parametrised multi-pipe LC4 register file. NREGS registers,
//            PIPES write ports and 2*PIPES read ports. Same-cycle writes are
//            bypassed to every reader, the highest-numbered pipe wins write
//            conflicts, and a per-register busy scoreboard tracks in-flight
//            producers so decode can stall.
// Ports    : clk        - rising-edge clock
//            rst        - asynchronous active-low reset
//            gwe        - global write enable, gates every state update
//            i_rs/i_rt  - per-pipe read selectors
//            o_rs_data/o_rt_data - bypassed read data
//            o_rs_busy/o_rt_busy - read register pending and not bypassed
//            i_rd/i_wdata/i_rd_we - per-pipe write ports
//            i_iss_rd/i_iss_we    - per-pipe issue (scoreboard set) ports
//            o_busy_cnt - registered popcount of the busy bits
// Revision : 1.0  initial release
// ============================================================================
module lc4_regfile_mp
    import lc4_regfile_mp_pkg::*;
#(
    parameter int n     = LC4_N,
    parameter int NREGS = LC4_NREGS,
    parameter int PIPES = LC4_PIPES,
    parameter int AW    = lc4_aw(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                gwe,
    input  logic [PIPES*AW-1:0] i_rs,
    output logic [PIPES*n-1:0]  o_rs_data,
    output logic [PIPES-1:0]    o_rs_busy,
    input  logic [PIPES*AW-1:0] i_rt,
    output logic [PIPES*n-1:0]  o_rt_data,
    output logic [PIPES-1:0]    o_rt_busy,
    input  logic [PIPES*AW-1:0] i_rd,
    input  logic [PIPES*n-1:0]  i_wdata,
    input  logic [PIPES-1:0]    i_rd_we,
    input  logic [PIPES*AW-1:0] i_iss_rd,
    input  logic [PIPES-1:0]    i_iss_we,
    output logic [AW:0]         o_busy_cnt
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [n-1:0]     r_regs_q [NREGS];
    logic [n-1:0]     w_regs_d [NREGS];
    logic [NREGS-1:0] r_busy_q;
    logic [NREGS-1:0] w_busy_d;
    logic [AW:0]      r_busy_cnt_q;
    logic [AW:0]      w_busy_cnt_d;

    // Per-register resolved commit (winning write across pipes).
    logic [NREGS-1:0] w_cwe;
    logic [n-1:0]     w_cdata [NREGS];

    // Per-register "some pipe issues a producer for this register".
    logic [NREGS-1:0] w_iss_hit;

    // ------------------------------------------------------------------
    // Commit selection: one winning-write selector per register
    // ------------------------------------------------------------------
    generate
        for (genvar r = 0; r < NREGS; r++) begin : g_commit
            lc4_rf_wsel #(
                .n     (n),
                .PIPES (PIPES),
                .AW    (AW)
            ) u_wsel (
                .i_sel   (AW'(r)),
                .i_rd    (i_rd),
                .i_rd_we (i_rd_we),
                .i_wdata (i_wdata),
                .o_we    (w_cwe[r]),
                .o_data  (w_cdata[r])
            );
        end
    endgenerate

    // ------------------------------------------------------------------
    // Issue decode: OR of all pipes issuing to each register
    // ------------------------------------------------------------------
    always_comb begin
        w_iss_hit = '0;
        for (int r = 0; r < NREGS; r++) begin
            for (int p = 0; p < PIPES; p++) begin
                if (i_iss_we[p] && (i_iss_rd[p*AW +: AW] == AW'(r))) begin
                    w_iss_hit[r] = 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state: storage, scoreboard and busy count
    // ------------------------------------------------------------------
    always_comb begin
        w_regs_d = r_regs_q;
        w_busy_d = r_busy_q;
        if (gwe) begin
            for (int r = 0; r < NREGS; r++) begin
                if (w_cwe[r]) begin
                    w_regs_d[r] = w_cdata[r];
                end
                // A same-cycle issue marks a newer producer in flight, so it
                // takes precedence over the clear from the completing write.
                if (w_iss_hit[r]) begin
                    w_busy_d[r] = 1'b1;
                end else if (w_cwe[r]) begin
                    w_busy_d[r] = 1'b0;
                end
            end
        end
    end

    // Count is taken from the next-state vector so the registered count
    // always matches the registered busy bits.
    always_comb begin
        w_busy_cnt_d = '0;
        for (int r = 0; r < NREGS; r++) begin
            w_busy_cnt_d = w_busy_cnt_d + {{AW{1'b0}}, w_busy_d[r]};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < NREGS; r++) begin
                r_regs_q[r] <= '0;
            end
            r_busy_q     <= '0;
            r_busy_cnt_q <= '0;
        end else begin
            r_regs_q     <= w_regs_d;
            r_busy_q     <= w_busy_d;
            r_busy_cnt_q <= w_busy_cnt_d;
        end
    end

    assign o_busy_cnt = r_busy_cnt_q;

    // ------------------------------------------------------------------
    // Read ports: two per pipe, each with its own bypass selector.
    // Bypass ignores gwe so decode sees the value being produced now.
    // ------------------------------------------------------------------
    logic [PIPES-1:0] w_rs_byp_we;
    logic [PIPES-1:0] w_rt_byp_we;
    logic [n-1:0]     w_rs_byp_data [PIPES];
    logic [n-1:0]     w_rt_byp_data [PIPES];

    generate
        for (genvar p = 0; p < PIPES; p++) begin : g_read
            localparam int c_a_lsb = slice_lsb(p, AW);
            localparam int c_d_lsb = slice_lsb(p, n);

            logic [AW-1:0] w_rs_sel;
            logic [AW-1:0] w_rt_sel;

            assign w_rs_sel = i_rs[c_a_lsb +: AW];
            assign w_rt_sel = i_rt[c_a_lsb +: AW];

            lc4_rf_wsel #(
                .n     (n),
                .PIPES (PIPES),
                .AW    (AW)
            ) u_rs_wsel (
                .i_sel   (w_rs_sel),
                .i_rd    (i_rd),
                .i_rd_we (i_rd_we),
                .i_wdata (i_wdata),
                .o_we    (w_rs_byp_we[p]),
                .o_data  (w_rs_byp_data[p])
            );

            lc4_rf_wsel #(
                .n     (n),
                .PIPES (PIPES),
                .AW    (AW)
            ) u_rt_wsel (
                .i_sel   (w_rt_sel),
                .i_rd    (i_rd),
                .i_rd_we (i_rd_we),
                .i_wdata (i_wdata),
                .o_we    (w_rt_byp_we[p]),
                .o_data  (w_rt_byp_data[p])
            );

            assign o_rs_data[c_d_lsb +: n] = w_rs_byp_we[p] ? w_rs_byp_data[p]
                                                            : r_regs_q[w_rs_sel];
            assign o_rt_data[c_d_lsb +: n] = w_rt_byp_we[p] ? w_rt_byp_data[p]
                                                            : r_regs_q[w_rt_sel];

            // A producer completing this cycle is not a stall: its data is
            // already on the bypass path.
            assign o_rs_busy[p] = r_busy_q[w_rs_sel] & ~w_rs_byp_we[p];
            assign o_rt_busy[p] = r_busy_q[w_rt_sel] & ~w_rt_byp_we[p];
        end
    endgenerate

endmodule : lc4_regfile_mp
`default_nettype wire
